pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: PCTarget  input  32  branch/jump target (PC + ImmExt) for the instruction currently presented.
REQ-005 Port: PCSrc  input  1  1 = take PCTarget as next PC; 0 = take PC+4; sampled only on instruction retire.
REQ-006 Port: Stall  input  1  1 = downstream cannot consume the presented instruction this cycle.
REQ-007 Port: IMemReq  output  1  instruction-memory read request.
REQ-008 Port: IMemAddr  output  32  fetch address; equals PC whenever IMemReq=1.
REQ-009 Port: IMemReady  input  1  memory returns IMemRdata this cycle; meaningful only while IMemReq=1.
REQ-010 Port: IMemRdata  input  32  fetched instruction word.
REQ-011 Port: Instr  output  32  registered instruction presented downstream.
REQ-012 Port: InstrValid  output  1  Instr, PC and PCPlus4 are valid.
REQ-013 Port: PC  output  32  address of the current fetch or presented instruction.
REQ-014 Port: PCPlus4  output  32  PC + 4, combinational, modulo 2^32.
REQ-015 Port: MisalignErr  output  1  sticky flag: a redirect to a non-word-aligned target was taken.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD and ERROR.
REQ-017 IDLE SHALL transition to FETCH on the first rising edge after rst_n deasserts, with IMemReq=0 while in IDLE.
REQ-018 In FETCH, IMemReq SHALL be 1 and IMemAddr SHALL equal PC.
REQ-019 In FETCH with IMemReady=1, the edge SHALL capture IMemRdata into Instr, set InstrValid=1 and enter HOLD.
REQ-020 In FETCH with IMemReady=0, the block SHALL stay in FETCH with PC and IMemAddr unchanged, for any number of cycles.
REQ-021 In HOLD, InstrValid SHALL be 1, IMemReq SHALL be 0, and Instr and PC SHALL be stable.
REQ-022 In HOLD with Stall=1, the block SHALL stay in HOLD, and PCSrc and PCTarget SHALL be ignored.
REQ-023 In HOLD with Stall=0 (retire), the edge SHALL load PC with PCTarget if PCSrc=1, else with PCPlus4, clear InstrValid and enter FETCH.
REQ-024 On retire with PCSrc=1 and PCTarget[1:0]!=2'b00, the block SHALL NOT update PC, SHALL set MisalignErr=1, clear InstrValid and enter ERROR.
REQ-025 ERROR SHALL be absorbing: IMemReq=0, InstrValid=0 and PC held; only reset exits it.
REQ-026 PC+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with IMemReady=1, then HOLD with Stall=0).
REQ-028 IMemReady asserted outside FETCH SHALL be ignored.
REQ-029 No request SHALL ever be outstanding across a PC change; PC SHALL change only on retire.

Reset
REQ-030 While rst_n=0, all outputs SHALL immediately take these values: state=IDLE, PC=RESET_PC, Instr=0, InstrValid=0, IMemReq=0, MisalignErr=0.
REQ-031 Reset asserted mid-fetch or in HOLD/ERROR SHALL abandon the operation immediately; no partial Instr capture is permitted.

Verification
REQ-032 Reset release, IMemReady=1 constant, Stall=0, PCSrc=0 -> IMemAddr sequence 0x0, 0x4, 0x8; InstrValid high every other cycle; Instr matches the memory model.
REQ-033 IMemReady held 0 for 5 cycles in FETCH at PC=0x10 -> IMemReq=1, IMemAddr=0x10 throughout; on the 6th cycle IMemReady=1 -> Instr captured, HOLD entered.
REQ-034 In HOLD at PC=0x20: Stall=1 for 3 cycles with PCSrc=1, PCTarget=0x100 -> no change; then Stall=0, PCSrc=1 -> next IMemAddr=0x100.
REQ-035 Retire at PC=0x40 with PCSrc=1, PCTarget=0x102 -> MisalignErr=1, PC stays 0x40, IMemReq stays 0 thereafter until reset.
REQ-036 RESET_PC=32'hFFFF_FFFC, retire with PCSrc=0 -> next IMemAddr=0x0, MisalignErr=0.
REQ-037 rst_n pulsed low while in FETCH with IMemReady=1 -> InstrValid=0, PC=RESET_PC, IMemReq=0 during reset; normal fetch resumes one cycle after release.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : Program-counter / instruction-fetch controller. Issues one
//            instruction-memory read per PC, registers the returned word,
//            presents it downstream until it retires, then advances the PC
//            sequentially or to a branch target. A misaligned redirect
//            parks the block in an absorbing error state until reset.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCTarget,
  input  logic        PCSrc,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_misalign;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_bad_redirect;

  // Sequential successor wraps naturally at 2^32.
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_next_pc      = PCSrc ? PCTarget : w_pc_plus4;
  // Only a taken redirect can produce a misaligned PC; PC+4 keeps alignment.
  assign w_bad_redirect = PCSrc && (PCTarget[1:0] != 2'b00);

  // Fetch FSM with registered request/valid/error outputs. The PC moves only
  // on a retire in HOLD, where no memory request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Wait as long as memory needs; address stays put meanwhile.
          if (IMemReady) begin
            r_instr <= IMemRdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Stall freezes everything; PCSrc/PCTarget matter only on retire.
          if (!Stall) begin
            r_valid <= 1'b0;
            if (w_bad_redirect) begin
              r_misalign <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= S_ERROR;
            end else begin
              r_pc    <= w_next_pc;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_ERROR: begin
          // Absorbing: only reset leaves this state.
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign IMemReq     = r_req;
  assign IMemAddr    = r_pc;
  assign Instr       = r_instr;
  assign InstrValid  = r_valid;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign MisalignErr = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Directed self-checking bench for pc_fetch_ctrl. Expected fetch
//            results are queued when a fetch is accepted and compared when
//            the instruction is presented downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst_n;
  logic [31:0] PCTarget;
  logic        PCSrc, Stall, IMemReady;
  logic [31:0] IMemRdata;
  logic        IMemReq, InstrValid, MisalignErr;
  logic [31:0] IMemAddr, Instr, PC, PCPlus4;

  // Wrap-around instance (RESET_PC = 0xFFFF_FFFC)
  logic        rst2_n;
  logic        Stall2, IMemReady2;
  logic [31:0] IMemRdata2;
  logic        IMemReq2, InstrValid2, MisalignErr2;
  logic [31:0] IMemAddr2, Instr2, PC2, PCPlus4_2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] held_instr;

  // Memory model: instruction word is a fixed scramble of its address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign IMemRdata  = mem_f(IMemAddr);
  assign IMemRdata2 = mem_f(IMemAddr2);

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .PCTarget(PCTarget), .PCSrc(PCSrc),
    .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemRdata(IMemRdata), .Instr(Instr),
    .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
    .MisalignErr(MisalignErr)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .PCTarget(32'h0000_0000), .PCSrc(1'b0),
    .Stall(Stall2), .IMemReq(IMemReq2), .IMemAddr(IMemAddr2),
    .IMemReady(IMemReady2), .IMemRdata(IMemRdata2), .Instr(Instr2),
    .InstrValid(InstrValid2), .PC(PC2), .PCPlus4(PCPlus4_2),
    .MisalignErr(MisalignErr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // In FETCH at exp_pc: verify request, then queue the expected capture.
  task automatic fetch_accept(input string tag);
    chk({tag, "_req"},  {31'd0, IMemReq}, 32'd1);
    chk({tag, "_addr"}, IMemAddr, exp_pc);
    sb.push_back('{pc: exp_pc, instr: mem_f(exp_pc)});
    IMemReady = 1'b1;
    cyc();
  endtask

  // In HOLD: pop the scoreboard and compare the presented instruction.
  task automatic hold_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, InstrValid}, 32'd1);
    chk({tag, "_hreq"},  {31'd0, IMemReq},    32'd0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, Instr, e.instr);
      chk({tag, "_pc"},    PC,    e.pc);
    end
  endtask

  initial begin
    rst_n = 1'b1; rst2_n = 1'b1;
    PCTarget = 32'd0; PCSrc = 1'b0; Stall = 1'b0; IMemReady = 1'b0;
    Stall2 = 1'b0; IMemReady2 = 1'b0;
    #2;
    rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    // Reset state, visible without a clock edge
    chk("rst_req",   {31'd0, IMemReq},     32'd0);
    chk("rst_valid", {31'd0, InstrValid},  32'd0);
    chk("rst_pc",    PC,                   32'd0);
    chk("rst_instr", Instr,                32'd0);
    chk("rst_err",   {31'd0, MisalignErr}, 32'd0);
    chk("rst_pc4",   PCPlus4,              32'd4);
    chk("rst2_pc",   PC2,                  32'hFFFF_FFFC);
    cyc(); cyc();
    rst_n = 1'b1;
    chk("idle_req", {31'd0, IMemReq}, 32'd0);
    cyc();

    // Back-to-back sequential fetches 0x0, 0x4, 0x8, 0xC
    exp_pc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      fetch_accept("seq");
      hold_check("seq");
      cyc();
      exp_pc = exp_pc + 32'd4;
    end

    // Memory wait states at PC=0x10
    IMemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wait_req",   {31'd0, IMemReq},    32'd1);
      chk("wait_addr",  IMemAddr,            32'h10);
      chk("wait_valid", {31'd0, InstrValid}, 32'd0);
      cyc();
    end
    fetch_accept("wait");
    hold_check("wait");

    // Redirect to 0x20, then stall in HOLD with a pending redirect
    PCSrc = 1'b1; PCTarget = 32'h20;
    cyc();
    exp_pc = 32'h20;
    fetch_accept("br20");
    hold_check("br20");
    held_instr = mem_f(32'h20);
    Stall = 1'b1; PCTarget = 32'h100;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc",    PC,                   32'h20);
      chk("stall_instr", Instr,                held_instr);
      chk("stall_valid", {31'd0, InstrValid},  32'd1);
      chk("stall_req",   {31'd0, IMemReq},     32'd0);
    end
    Stall = 1'b0;
    cyc();
    exp_pc = 32'h100;
    fetch_accept("br100");
    hold_check("br100");

    // Redirect to 0x40, then misaligned redirect to 0x102
    PCTarget = 32'h40;
    cyc();
    exp_pc = 32'h40;
    fetch_accept("br40");
    hold_check("br40");
    PCTarget = 32'h102;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("err_flag",  {31'd0, MisalignErr}, 32'd1);
      chk("err_pc",    PC,                   32'h40);
      chk("err_req",   {31'd0, IMemReq},     32'd0);
      chk("err_valid", {31'd0, InstrValid},  32'd0);
      cyc();
    end

    // Reset exits ERROR; then reset pulsed in FETCH with IMemReady=1
    PCSrc = 1'b0; PCTarget = 32'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_err_clr", {31'd0, MisalignErr}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("refetch_req", {31'd0, IMemReq}, 32'd1);
    IMemReady = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, InstrValid}, 32'd0);
    chk("midrst_pc",    PC,                  32'd0);
    chk("midrst_req",   {31'd0, IMemReq},    32'd0);
    cyc();
    chk("midrst_instr", Instr, 32'd0);
    rst_n = 1'b1;
    IMemReady = 1'b0;
    chk("post_idle_req", {31'd0, IMemReq}, 32'd0);
    cyc();
    exp_pc = 32'd0;
    fetch_accept("resume");
    hold_check("resume");

    // PC+4 wrap at 0xFFFF_FFFC on the second instance
    rst2_n = 1'b1;
    cyc();
    chk("wrap_req",  {31'd0, IMemReq2}, 32'd1);
    chk("wrap_addr", IMemAddr2,         32'hFFFF_FFFC);
    chk("wrap_pc4",  PCPlus4_2,         32'h0000_0000);
    IMemReady2 = 1'b1;
    cyc();
    chk("wrap_valid", {31'd0, InstrValid2}, 32'd1);
    chk("wrap_instr", Instr2,               mem_f(32'hFFFF_FFFC));
    cyc();
    chk("wrap_next_addr", IMemAddr2,            32'h0000_0000);
    chk("wrap_next_req",  {31'd0, IMemReq2},    32'd1);
    chk("wrap_err",       {31'd0, MisalignErr2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
